// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Default timings are 640x480@60 on a 25.2 MHz pixel clock.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PREFETCH = 2;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
  } pos_t;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          sof;
    logic          eol;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vga_out_t;

  typedef struct packed {
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } req_out_t;

  function automatic int h_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act, input int fp,
    input int sync, input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync2.sv
// Two-flop level synchroniser for a slow asynchronous flag.
// Synchronous active-low reset clears both stages.
module vga_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // next state of the two synchroniser stages
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // shift the flag through both stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, registered sync/de/coordinate
// outputs, and a look-ahead fetch request running PREFETCH pixels early.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PREFETCH = DEF_PREFETCH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 1024) begin : g_bad_h
    $error("H_TOTAL exceeds 10-bit counter");
  end
  if (V_TOTAL > 1024) begin : g_bad_v
    $error("V_TOTAL exceeds 10-bit counter");
  end
  if (PREFETCH < 1 ||
      PREFETCH > H_FP + H_SYNC + H_BP) begin : g_bad_pf
    $error("PREFETCH outside horizontal blanking");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_HI  =
    CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_HI  =
    CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] PF     = CW'(PREFETCH);

  localparam pos_t POS_ZERO = '{h: '0, v: '0};
  localparam pos_t POS_REQ0 = '{h: PF, v: '0};

  localparam vga_out_t OUT_IDLE = '{
    hs: ~HS_POL, vs: ~VS_POL, de: 1'b0,
    sof: 1'b0, eol: 1'b0, x: '0, y: '0
  };
  localparam req_out_t REQ_IDLE = '{
    req: 1'b0, x: '0, y: '0
  };

  function automatic pos_t advance(input pos_t p);
    pos_t n;
    n = p;
    if (p.h == H_LAST) begin
      n.h = '0;
      n.v = (p.v == V_LAST) ? '0 : p.v + 1'b1;
    end else begin
      n.h = p.h + 1'b1;
    end
    return n;
  endfunction

  function automatic vga_out_t decode(input pos_t p);
    vga_out_t o;
    logic     act;
    logic     hs_on;
    logic     vs_on;
    act   = (p.h < H_ACT) && (p.v < V_ACT);
    hs_on = (p.h >= HS_LO) && (p.h <= HS_HI);
    vs_on = (p.v >= VS_LO) && (p.v <= VS_HI);
    o.hs  = hs_on ? HS_POL : ~HS_POL;
    o.vs  = vs_on ? VS_POL : ~VS_POL;
    o.de  = act;
    o.sof = act && (p.h == '0) && (p.v == '0);
    o.eol = act && (p.h == H_EOL);
    o.x   = act ? p.h : '0;
    o.y   = act ? p.v : '0;
    return o;
  endfunction

  logic     run;
  logic     act_q, act_d;
  pos_t     pos_q, pos_d;
  pos_t     rpos_q, rpos_d;
  vga_out_t out_q, out_d;
  req_out_t rq_q, rq_d;
  vga_out_t rdec;

  vga_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (run)
  );

  // act_q marks the cycle after run rises so (0,0) is decoded once
  // before the counters start moving; loss of run clears everything
  always_comb begin
    act_d  = run;
    pos_d  = POS_ZERO;
    rpos_d = POS_REQ0;
    out_d  = OUT_IDLE;
    rq_d   = REQ_IDLE;
    rdec   = decode(rpos_q);
    if (run && act_q) begin
      pos_d  = advance(pos_q);
      rpos_d = advance(rpos_q);
      out_d  = decode(pos_q);
      rq_d   = '{req: rdec.de, x: rdec.x, y: rdec.y};
    end
  end

  // counters and the output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      pos_q  <= POS_ZERO;
      rpos_q <= POS_REQ0;
      out_q  <= OUT_IDLE;
      rq_q   <= REQ_IDLE;
    end else begin
      act_q  <= act_d;
      pos_q  <= pos_d;
      rpos_q <= rpos_d;
      out_q  <= out_d;
      rq_q   <= rq_d;
    end
  end

  assign hsync = out_q.hs;
  assign vsync = out_q.vs;
  assign de    = out_q.de;
  assign sof   = out_q.sof;
  assign eol   = out_q.eol;
  assign pix_x = out_q.x;
  assign pix_y = out_q.y;
  assign req   = rq_q.req;
  assign req_x = rq_q.x;
  assign req_y = rq_q.y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster
// (32 x 19 totals) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int PF = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       hsync, vsync, de, sof, eol, req;
  logic [9:0] pix_x, pix_y, req_x, req_y;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1'b0), .VS_POL (1'b0), .PREFETCH (PF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .eol        (eol),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit de; int x; int y;
    bit hs; bit vs; bit sof; bit eol;
    bit req; int rx; int ry;
  } vec_t;

  typedef struct {
    bit v; int x; int y;
  } hist_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc;
  bit     model_on;
  vec_t   vecs[$];
  hist_t  hist[$];

  function automatic vec_t mk(
    int n, bit de_, int x, int y, bit hs, bit vs,
    bit sf, bit el, bit rq, int rx, int ry
  );
    vec_t v;
    v.n = n; v.de = de_; v.x = x; v.y = y;
    v.hs = hs; v.vs = vs; v.sof = sf; v.eol = el;
    v.req = rq; v.rx = rx; v.ry = ry;
    return v;
  endfunction

  function automatic logic [45:0] pk(vec_t v);
    return {v.de, v.hs, v.vs, v.sof, v.eol, v.req,
            10'(v.x), 10'(v.y), 10'(v.rx), 10'(v.ry)};
  endfunction

  function automatic logic [45:0] got();
    return {de, hsync, vsync, sof, eol, req,
            pix_x, pix_y, req_x, req_y};
  endfunction

  task automatic chk(string nm, logic [45:0] g, logic [45:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h exp %h", nm, cyc, g, e);
    end
  endtask

  // independent raster model: position n cycles after first (0,0)
  function automatic vec_t model(int n);
    int h, v, rh, rv;
    bit a, ra;
    h  = n % HT;
    v  = (n / HT) % VT;
    rh = (n + PF) % HT;
    rv = ((n + PF) / HT) % VT;
    a  = (h < HA) && (v < VA);
    ra = (rh < HA) && (rv < VA);
    return mk(n, a, a ? h : 0, a ? v : 0,
              !(h >= HA + HF && h < HA + HF + HS),
              !(v >= VA + VF && v < VA + VF + VS),
              a && h == 0 && v == 0, a && h == HA - 1,
              ra, ra ? rh : 0, ra ? rv : 0);
  endfunction

  task automatic model_chk();
    hist_t h, c;
    chk("model", got(), pk(model(cyc)));
    if (hist.size() == PF) begin
      h = hist.pop_front();
      if (h.v)
        chk("req_lead", {de, pix_x, pix_y},
            {1'b1, 10'(h.x), 10'(h.y)});
    end
    c.v = req; c.x = int'(req_x); c.y = int'(req_y);
    hist.push_back(c);
  endtask

  task automatic idle_chk(string nm);
    chk(nm, got(), pk(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (model_on) model_chk();
  endtask

  // three idle edges after run rises, then the 4th shows (0,0)
  task automatic start_seq(string nm);
    repeat (3) step();
    idle_chk({nm, "_e3"});
    step();
    cyc = 0;
    hist.delete();
    model_on = 1'b1;
    chk({nm, "_sof"}, {de, sof, pix_x, pix_y}, {2'b11, 20'd0});
    model_chk();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0,   1, 0,  0,  1, 1, 1, 0, 1, 2,  0));
    vecs.push_back(mk(13,  1, 13, 0,  1, 1, 0, 0, 1, 15, 0));
    vecs.push_back(mk(14,  1, 14, 0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(15,  1, 15, 0,  1, 1, 0, 1, 0, 0,  0));
    vecs.push_back(mk(16,  0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(19,  0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(20,  0, 0,  0,  0, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(25,  0, 0,  0,  0, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(26,  0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(30,  0, 0,  0,  1, 1, 0, 0, 1, 0,  1));
    vecs.push_back(mk(32,  1, 0,  1,  1, 1, 0, 0, 1, 2,  1));
    vecs.push_back(mk(367, 1, 15, 11, 1, 1, 0, 1, 0, 0,  0));
    vecs.push_back(mk(384, 0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(447, 0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(448, 0, 0,  0,  1, 0, 0, 0, 0, 0,  0));
    vecs.push_back(mk(511, 0, 0,  0,  1, 0, 0, 0, 0, 0,  0));
    vecs.push_back(mk(512, 0, 0,  0,  1, 1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(606, 0, 0,  0,  1, 1, 0, 0, 1, 0,  0));
    vecs.push_back(mk(607, 0, 0,  0,  1, 1, 0, 0, 1, 1,  0));
    vecs.push_back(mk(608, 1, 0,  0,  1, 1, 1, 0, 1, 2,  0));
    vecs.push_back(mk(623, 1, 15, 0,  1, 1, 0, 1, 0, 0,  0));

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    model_on   = 1'b0;
    cyc        = 0;
    repeat (3) step();
    idle_chk("reset");

    rst_n = 1'b1;
    repeat (100) begin
      step();
      idle_chk("unlocked");
    end

    pll_locked = 1'b1;
    start_seq("lock");

    foreach (vecs[i]) begin
      while (cyc < vecs[i].n) step();
      chk($sformatf("vec%0d", vecs[i].n), got(), pk(vecs[i]));
    end

    while (cyc < 776) step();
    pll_locked = 1'b0;
    model_on   = 1'b0;
    repeat (3) step();
    idle_chk("unlock3");
    repeat (5) begin
      step();
      idle_chk("unlocked2");
    end

    pll_locked = 1'b1;
    start_seq("relock");
    repeat (150) step();

    model_on = 1'b0;
    rst_n    = 1'b0;
    step();
    idle_chk("rst_mid");
    step();
    idle_chk("rst_hold");
    rst_n = 1'b1;
    start_seq("rst_rel");
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
